mem_a_skew_buf: RTL and testbench

MEM_A_SKEW_BUF -- requirements
Module: mem_a_skew_buf

---
 rtl/mem_a_skew_buf.sv | 128 ++++++++++++
 tb/tb_mem_a_skew_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_a_skew_buf.sv
// Row-loaded DIM x DIM operand buffer that drains as a diagonal wavefront,
// so that lane r lags lane r-1 by one step, ready to feed a systolic array.
module mem_a_skew_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            WrEn,
  input  logic [$clog2(DIM)-1:0]          Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]     Ain,
  input  logic                            tr,
  input  logic                            start,
  input  logic                            clr,
  output logic                            full,
  output logic                            busy,
  output logic [DIM-1:0][BITS_AB-1:0]     Aout,
  output logic                            Aout_valid,
  output logic                            done
);

  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

  localparam logic STATE_LOAD  = 1'b0;
  localparam logic STATE_DRAIN = 1'b1;

  logic                          stateQ, stateD;
  logic [TW-1:0]                 tQ, tD;
  logic                          trQ, trD;
  logic [DIM-1:0]                maskQ, maskD;
  logic [DIM-1:0][BITS_AB-1:0]   aoutQ, aoutD;
  logic                          validQ, validD;
  logic                          doneQ, doneD;
  logic [DIM-1:0][BITS_AB-1:0]   skew;
  logic                          rowOk;

  // Matrix storage is never reset; the row mask alone decides what is usable.
  logic [BITS_AB-1:0]            mQ [DIM][DIM];

  assign rowOk      = (int'(Arow) < DIM);
  assign full       = &maskQ;
  assign busy       = (stateQ == STATE_DRAIN);
  assign Aout       = aoutQ;
  assign Aout_valid = validQ;
  assign done       = doneQ;

  always_ff @(posedge clk) begin
    if (stateQ == STATE_LOAD && WrEn && rowOk) begin
      for (int c = 0; c < DIM; c++) begin
        mQ[Arow][c] <= Ain[c];
      end
    end
  end

  // Lane r at step t shows element k = t - r of its row/column, zero outside.
  always_comb begin
    skew = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int k = 0; k < DIM; k++) begin
        if (int'(tQ) == r + k) begin
          skew[r] = trQ ? mQ[r][k] : mQ[k][r];
        end
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    tD     = tQ;
    trD    = trQ;
    maskD  = maskQ;
    aoutD  = '0;
    validD = 1'b0;
    doneD  = 1'b0;
    case (stateQ)
      STATE_LOAD: begin
        if (clr) begin
          maskD = '0;
        end else if (WrEn && rowOk) begin
          maskD[Arow] = 1'b1;
        end
        if (start && full) begin
          stateD = STATE_DRAIN;
          trD    = tr;
          tD     = '0;
        end
      end
      default: begin
        if (en) begin
          validD = 1'b1;
          aoutD  = skew;
          if (tQ == T_LAST) begin
            stateD = STATE_LOAD;
            maskD  = '0;
            doneD  = 1'b1;
          end else begin
            tD = tQ + TW'(1);
          end
        end else begin
          aoutD = aoutQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= STATE_LOAD;
      tQ     <= '0;
      trQ    <= 1'b0;
      maskQ  <= '0;
      aoutQ  <= '0;
      validQ <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      tQ     <= tD;
      trQ    <= trD;
      maskQ  <= maskD;
      aoutQ  <= aoutD;
      validQ <= validD;
      doneQ  <= doneD;
    end
  end

endmodule

// File: tb/tb_mem_a_skew_buf.sv
// Directed bench for mem_a_skew_buf (DIM=4, BITS_AB=8) with M[r][c] = 10r+c;
// expected drain vectors go into a queue that a negedge monitor consumes.
module tb_mem_a_skew_buf;

  localparam int DIM  = 4;
  localparam int BITS = 8;

  typedef logic [DIM-1:0][BITS-1:0] vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       WrEn  = 1'b0;
  logic       tr    = 1'b0;
  logic       start = 1'b0;
  logic       clr   = 1'b0;
  logic [1:0] Arow  = '0;
  vec_t       Ain   = '0;
  vec_t       Aout;
  logic       full, busy, Aout_valid, done;

  vec_t expQ[$];
  vec_t lastExp;
  vec_t monExp;
  int   checks   = 0;
  int   failures = 0;

  mem_a_skew_buf #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .tr(tr), .start(start), .clr(clr), .full(full), .busy(busy),
    .Aout(Aout), .Aout_valid(Aout_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Closed-form wavefront for the 10r+c test matrix.
  function automatic vec_t expStep(input int t, input logic trV);
    vec_t v = '0;
    for (int r = 0; r < DIM; r++) begin
      int k = t - r;
      if (k >= 0 && k < DIM) v[r] = trV ? 8'(10 * r + k) : 8'(10 * k + r);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (Aout_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid actual=%0h required=none", Aout);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("drain_lanes", Aout, monExp);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input int row, input logic st, input logic cl);
    WrEn  = wr;
    Arow  = 2'(row);
    start = st;
    clr   = cl;
    for (int c = 0; c < DIM; c++) Ain[c] = 8'(10 * row + c);
    cycle();
    WrEn  = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic loadRows(input int n);
    for (int r = 0; r < n; r++) applyStimulus(1'b1, r, 1'b0, 1'b0);
  endtask

  task automatic startDrain(input logic trV, input logic expectBusy);
    tr    = trV;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("busy_after_start", busy, expectBusy);
  endtask

  task automatic drainSteps(input logic trV, input int mode);
    int s   = 0;
    int cyc = 0;
    while (s < 2 * DIM - 1 && cyc < 60) begin
      en = (mode == 0) || (cyc % 3 == 0);
      if (en) begin
        lastExp = expStep(s, trV);
        expQ.push_back(lastExp);
        s++;
      end
      cycle();
      if (!en) begin
        checkOutput("hold_valid_low", Aout_valid, 0);
        checkOutput("hold_data", Aout, lastExp);
      end
      if (s < 2 * DIM - 1) checkOutput("busy_mid_drain", busy, 1);
      cyc++;
    end
    en = 1'b0;
    if (s < 2 * DIM - 1) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=%0d", s, 2 * DIM - 1);
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_after_last", busy, 0);
    checkOutput("full_cleared", full, 0);
  endtask

  task automatic checkIdleNow();
    checkOutput("idle_done", done, 0);
    checkOutput("idle_valid", Aout_valid, 0);
    checkOutput("idle_aout", Aout, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset_aout", Aout, 0);
    checkOutput("reset_valid", Aout_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_done", done, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    $display("[TB] column-streaming drain");
    loadRows(DIM);
    checkOutput("full_after_load", full, 1);
    startDrain(1'b0, 1'b1);
    drainSteps(1'b0, 0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    checkIdleNow();
    for (int r = 1; r < DIM; r++) applyStimulus(1'b1, r, 1'b0, 1'b0);
    checkOutput("full_with_done_cycle_write", full, 1);

    $display("[TB] transposed drain");
    startDrain(1'b1, 1'b1);
    drainSteps(1'b1, 0);
    cycle();
    checkIdleNow();

    $display("[TB] drain with enable gaps");
    loadRows(DIM);
    startDrain(1'b0, 1'b1);
    drainSteps(1'b0, 1);
    cycle();
    checkIdleNow();

    $display("[TB] start gated by full");
    loadRows(DIM - 1);
    checkOutput("partial_not_full", full, 0);
    startDrain(1'b0, 1'b0);
    applyStimulus(1'b1, DIM - 1, 1'b1, 1'b0);
    checkOutput("start_with_last_write", busy, 0);
    checkOutput("full_after_last_write", full, 1);
    startDrain(1'b0, 1'b1);
    drainSteps(1'b0, 0);
    cycle();
    checkIdleNow();

    $display("[TB] clear beats write");
    loadRows(DIM);
    applyStimulus(1'b1, 1, 1'b0, 1'b1);
    checkOutput("full_after_clr", full, 0);
    startDrain(1'b0, 1'b0);

    $display("[TB] reset mid drain");
    loadRows(DIM);
    startDrain(1'b0, 1'b1);
    en = 1'b1;
    expQ.push_back(expStep(0, 1'b0));
    cycle();
    expQ.push_back(expStep(1, 1'b0));
    cycle();
    en = 1'b0;
    #6 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_aout", Aout, 0);
    checkOutput("async_reset_valid", Aout_valid, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_full", full, 0);
    checkOutput("async_reset_done", done, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    startDrain(1'b0, 1'b0);
    loadRows(DIM);
    startDrain(1'b0, 1'b1);
    drainSteps(1'b0, 0);
    cycle();
    checkIdleNow();

    repeat (3) cycle();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
